// File: rtl/pwm_demod_pkg.sv
// ============================================================================
// Module      : pwm_demod_pkg
// Description : Shared FSM state type, output width and result-shift helper
//               for the PWM demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_demod_pkg;

  localparam int OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Left shift that places a FRAME_BITS+AVG_LOG2 wide count at the top of OUT_W.
  function automatic int result_shift(input int frame_bits, input int avg_log2);
    return OUT_W - frame_bits - avg_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// Module      : bit_sync
// Description : Two-flop synchronizer for a single asynchronous bit,
//               asynchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] r_meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 2'b00;
    end else begin
      r_meta <= {r_meta[0], d};
    end
  end

  assign q = r_meta[1];

endmodule

`default_nettype wire

// File: rtl/pwm_demod.sv
// ============================================================================
// Module      : pwm_demod
// Description : Integrates PWM high time over 2^AVG_LOG2 frames and reports
//               the reconstructed 32-bit target value. Optional 3-sample
//               majority glitch filter via PWM_DEMOD_GLITCH_FILT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int AVG_LOG2   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             sat
);

  localparam int CNT_W = FRAME_BITS + AVG_LOG2;
  localparam int SHIFT = result_shift(FRAME_BITS, AVG_LOG2);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_win;
  logic [CNT_W-1:0]    r_high;
  logic [FRAME_BITS-1:0] r_timeout;
  logic [OUT_W-1:0]    r_result;
  logic                r_result_valid;
  logic                r_sat;
  logic                r_sample_d;
  logic                w_sync;
  logic                w_sample;
  logic                w_rise;
  logic                w_close;
  logic [CNT_W:0]      w_sum;
  logic [CNT_W-1:0]    w_final;

  bit_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .q   (w_sync)
  );

`ifdef PWM_DEMOD_GLITCH_FILT_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 2'b00;
    end else begin
      r_hist <= {r_hist[0], w_sync};
    end
  end

  // Majority of the current and two previous synchronized samples.
  assign w_sample = (w_sync & r_hist[0]) | (w_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_sample = w_sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_d <= 1'b0;
    end else begin
      r_sample_d <= w_sample;
    end
  end

  assign w_rise = w_sample & ~r_sample_d;

  // Only an all-high window can carry into the extra bit; clamp it to W-1.
  assign w_sum   = {1'b0, r_high} + {{CNT_W{1'b0}}, w_sample};
  assign w_final = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = ALIGN;
      end
      ALIGN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (w_rise || (r_timeout == {FRAME_BITS{1'b1}})) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_close = (r_win == {CNT_W{1'b1}});
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win          <= '0;
      r_high         <= '0;
      r_timeout      <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (!enable) begin
        // Aborting discards the partial window; result keeps its old value.
        r_win     <= '0;
        r_high    <= '0;
        r_timeout <= '0;
        r_sat     <= 1'b0;
      end else begin
        case (r_state)
          ALIGN: begin
            r_win  <= '0;
            r_high <= '0;
            if (w_state_nxt == ACCUM) begin
              r_timeout <= '0;
            end else begin
              r_timeout <= r_timeout + 1'b1;
            end
          end
          ACCUM: begin
            if (w_close) begin
              r_result       <= OUT_W'(w_final) << SHIFT;
              r_result_valid <= 1'b1;
              r_sat          <= r_sat | w_sum[CNT_W];
              r_win          <= '0;
              r_high         <= '0;
            end else begin
              r_win  <= r_win + 1'b1;
              r_high <= w_sum[CNT_W-1:0];
            end
          end
          default: begin
            r_win     <= '0;
            r_high    <= '0;
            r_timeout <= '0;
          end
        endcase
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign sat          = r_sat;
  assign busy         = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/pwm_demod.md
# pwm_demod

Demodulator for the output of the cascaded noise-shaped PWM modulator chain. It samples one PWM bitstream pin and integrates the high time over a window of whole PWM frames. It then reports the reconstructed 32-bit target value, on the same scale as the modulator's 32-bit target input. The block sits on the bench/loopback side of the design and closes the loop for self-test and calibration.

## Interface
- FRAME_BITS, 16, log2 of PWM frame length in clocks (matches the 16-bit stage value width)
- AVG_LOG2, 4, log2 of frames integrated per result window
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  reset, asynchronous, active-low
- pwm_in  input  1  PWM bitstream, asynchronous to clk
- enable  input  1  run/stop; low aborts and idles
- result  output  32  last reconstructed target value
- result_valid  output  1  one-cycle strobe, result updated this cycle
- busy  output  1  high in ALIGN or ACCUM
- sat  output  1  sticky: a window saturated; cleared by reset or enable low

## Operation
- pwm_in passes through a 2-flop synchronizer, then a rising-edge detector.
- Window length W = 2^(FRAME_BITS+AVG_LOG2) clocks. The high counter is FRAME_BITS+AVG_LOG2 bits wide.
- FSM states: IDLE, ALIGN, ACCUM.
  - IDLE: counters cleared. enable=1 -> ALIGN.
  - ALIGN: wait for a synchronized rising edge, or a timeout of 2^FRAME_BITS clocks. Either event -> ACCUM with window counter 0. enable=0 -> IDLE.
  - ACCUM: every cycle, window counter +1 and high counter +sync_in.
    - When the window counter reaches W-1, the window closes. Load result, pulse result_valid, clear both counters and stay in ACCUM. Windows run back-to-back with no realignment.
    - enable=0 -> IDLE. The partial window is discarded, there is no strobe, and result holds its old value.
- Arithmetic:
  - An all-high window gives count W, which does not fit the counter. The high count saturates at W-1 and sets sat.
  - result = count << (32 - FRAME_BITS - AVG_LOG2), zero-filled LSBs.
- The edge on the final cycle's sample is counted. Window close and enable falling in the same cycle: enable wins, with no strobe.
- Reset mid-window: all state returns immediately to reset values, with no strobe.

## Timing
- Reset values: result=0, result_valid=0, busy=0, sat=0, FSM=IDLE.
- Synchronizer latency from pwm_in to the sampled bit is 2 clocks (3 with the filter below).
- busy rises the cycle after enable is sampled high, and falls the cycle after enable is sampled low.
- result and result_valid are registered and change on the clock after the last window cycle.
- Strobe spacing in steady state is exactly W clocks.
- The first strobe comes W+1 clocks after the ALIGN exit.

## Configuration
- PWM_DEMOD_GLITCH_FILT_EN
  - Defined: a 3-sample majority filter follows the synchronizer. Isolated single-cycle pulses and dropouts are rejected, and input latency grows by 1 clock.
  - Undefined: the synchronizer output feeds the counter directly, and every high sample counts.

## Structure
- Shared package pwm_demod_pkg holds:
  - the state enum (IDLE, ALIGN, ACCUM)
  - the OUT_W=32 constant
  - a function returning the result shift for the given FRAME_BITS/AVG_LOG2
- One sub-module: bit_sync, a 2-flop synchronizer with asynchronous active-low reset to 0, reusable elsewhere.
- The FSM, counters and optional filter live in pwm_demod.

## Test plan
All cases use FRAME_BITS=4 and AVG_LOG2=2: W=64, shift 26, ALIGN timeout 16.
- Constant pwm_in=1, enable=1 -> result=0xFC000000 and sat=1 on every strobe; strobes 64 clocks apart.
- Constant pwm_in=0 -> ALIGN times out after 16 clocks; result=0x00000000 every 64 clocks; sat=0.
- 25% duty (4 high of every 16) -> count 16 -> result=0x40000000 and result_valid once per 64 clocks.
- enable dropped at window cycle 30, raised again 5 clocks later -> no strobe, result unchanged, busy low for at least 1 cycle, fresh ALIGN.
- rst asserted mid-window -> on the same edge, result=0, result_valid=0, busy=0, sat=0; after release and enable, normal operation resumes.
- Single-cycle high pulse every 16 clocks -> with PWM_DEMOD_GLITCH_FILT_EN, result=0x00000000; without it, count 4 -> result=0x10000000.
